// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : game_sequencer_if
// Brief  : Bundle between the round controller and its neighbours: frame
//          ticks, player/collision events in, ball and auto-player controls
//          plus scoreboard out.
// Rev    : 1.0  initial release
// ============================================================================
interface game_sequencer_if;
  logic       tick;
  logic       start;
  logic       pause;
  logic [1:0] mode;
  logic       hit_l;
  logic       hit_r;
  logic       miss_l;
  logic       miss_r;
  logic       ball_rst;
  logic       ball_go;
  logic       serve_dir;
  logic       turn;
  logic       ai_en;
  logic       frz;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] winner;
  logic [1:0] mode_q;
  logic [2:0] state;

  // Drives events, observes the round controller
  modport master (
    output tick, start, pause, mode, hit_l, hit_r, miss_l, miss_r,
    input  ball_rst, ball_go, serve_dir, turn, ai_en, frz,
    input  score_l, score_r, winner, mode_q, state
  );

  // The round controller itself
  modport slave (
    input  tick, start, pause, mode, hit_l, hit_r, miss_l, miss_r,
    output ball_rst, ball_go, serve_dir, turn, ai_en, frz,
    output score_l, score_r, winner, mode_q, state
  );
endinterface
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module : game_sequencer
// Brief  : Round-level controller for the ball-and-paddle game. Sequences
//          idle / serve countdown / play / point pause / game over, keeps the
//          scores and drives ball reset, launch, serve direction and the
//          auto-player enable. Every output comes straight from a flop.
// Rev    : 1.0  initial release
// ============================================================================
module game_sequencer #(
  parameter int SERVE_TICKS = 60,
  parameter int PAUSE_TICKS = 90,
  parameter int WIN_SCORE   = 7
) (
  input  wire logic         clk,
  input  wire logic         rst,
  game_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_SCORED = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam int MAX_TICKS = (SERVE_TICKS > PAUSE_TICKS) ? SERVE_TICKS : PAUSE_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_TICKS - 1);
  localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_TICKS - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  state_t        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [3:0]    score_l_q,   score_l_d;
  logic [3:0]    score_r_q,   score_r_d;
  logic [1:0]    winner_q,    winner_d;
  logic [1:0]    mode_q_q,    mode_q_d;
  logic          serve_dir_q, serve_dir_d;
  logic          turn_q,      turn_d;
  logic          ball_rst_q,  ball_rst_d;
  logic          ball_go_q,   ball_go_d;
  logic          ai_en_q,     ai_en_d;
  logic          frz_q,       frz_d;

  // Next-state and next-output computation; outputs are derived from the
  // next state so that they are valid in the same cycle as the state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    mode_q_d    = mode_q_q;
    serve_dir_d = serve_dir_q;
    turn_d      = turn_q;
    ball_go_d   = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          state_d     = S_SERVE;
          mode_q_d    = (bus.mode == 2'b11) ? 2'b00 : bus.mode;
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          winner_d    = 2'b00;
          serve_dir_d = 1'b1;
          cnt_d       = '0;
        end
      end
      S_SERVE: begin
        if (bus.tick && !bus.pause) begin
          if (cnt_q == SERVE_LAST) begin
            state_d   = S_PLAY;
            cnt_d     = '0;
            ball_go_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        // Misses outrank hits; a double miss is a replay with no score.
        if (!bus.pause) begin
          if (bus.miss_l && bus.miss_r) begin
            state_d = S_SCORED;
            cnt_d   = '0;
          end else if (bus.miss_l) begin
            score_r_d   = score_r_q + 4'd1;
            serve_dir_d = 1'b0;
            cnt_d       = '0;
            if (score_r_d == WIN) begin
              state_d  = S_OVER;
              winner_d = 2'b10;
            end else begin
              state_d = S_SCORED;
            end
          end else if (bus.miss_r) begin
            score_l_d   = score_l_q + 4'd1;
            serve_dir_d = 1'b1;
            cnt_d       = '0;
            if (score_l_d == WIN) begin
              state_d  = S_OVER;
              winner_d = 2'b01;
            end else begin
              state_d = S_SCORED;
            end
          end else if (bus.hit_l || bus.hit_r) begin
            turn_d = ~turn_q;
          end
        end
      end
      S_SCORED: begin
        if (bus.tick && !bus.pause) begin
          if (cnt_q == PAUSE_LAST) begin
            state_d = S_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == S_SERVE) begin
      turn_d = serve_dir_d;
    end
    ball_rst_d = (state_d != S_PLAY);
    ai_en_d    = (state_d == S_PLAY) && !bus.pause;
    frz_d      = (state_d == S_PLAY) &&  bus.pause;
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      winner_q    <= 2'b00;
      mode_q_q    <= 2'b00;
      serve_dir_q <= 1'b1;
      turn_q      <= 1'b0;
      ball_rst_q  <= 1'b1;
      ball_go_q   <= 1'b0;
      ai_en_q     <= 1'b0;
      frz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      mode_q_q    <= mode_q_d;
      serve_dir_q <= serve_dir_d;
      turn_q      <= turn_d;
      ball_rst_q  <= ball_rst_d;
      ball_go_q   <= ball_go_d;
      ai_en_q     <= ai_en_d;
      frz_q       <= frz_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.winner    = winner_q;
  assign bus.mode_q    = mode_q_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.turn      = turn_q;
  assign bus.ball_rst  = ball_rst_q;
  assign bus.ball_go   = ball_go_q;
  assign bus.ai_en     = ai_en_q;
  assign bus.frz       = frz_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_game_sequencer
// Brief  : Directed self-checking bench for game_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_game_sequencer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  game_sequencer_if bus ();

  game_sequencer #(
    .SERVE_TICKS (60),
    .PAUSE_TICKS (90),
    .WIN_SCORE   (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One idle clk then a one-clk tick; returns just after the edge sampling it
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
    end
  endtask

  // One-clk pulse on the selected event inputs
  task automatic pulse(input logic s, input logic ml, input logic mr,
                       input logic hl, input logic hr);
    bus.start  = s;
    bus.miss_l = ml;
    bus.miss_r = mr;
    bus.hit_l  = hl;
    bus.hit_r  = hr;
    cyc();
    bus.start  = 1'b0;
    bus.miss_l = 1'b0;
    bus.miss_r = 1'b0;
    bus.hit_l  = 1'b0;
    bus.hit_r  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},     int'(bus.state),     0);
    check({tag, "_score_l"},   int'(bus.score_l),   0);
    check({tag, "_score_r"},   int'(bus.score_r),   0);
    check({tag, "_ball_rst"},  int'(bus.ball_rst),  1);
    check({tag, "_ball_go"},   int'(bus.ball_go),   0);
    check({tag, "_serve_dir"}, int'(bus.serve_dir), 1);
    check({tag, "_turn"},      int'(bus.turn),      0);
    check({tag, "_ai_en"},     int'(bus.ai_en),     0);
    check({tag, "_frz"},       int'(bus.frz),       0);
    check({tag, "_winner"},    int'(bus.winner),    0);
    check({tag, "_mode_q"},    int'(bus.mode_q),    0);
  endtask

  // Watchdog so the run can never hang
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.tick   = 1'b0;
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.mode   = 2'b11;
    bus.hit_l  = 1'b0;
    bus.hit_r  = 1'b0;
    bus.miss_l = 1'b0;
    bus.miss_r = 1'b0;

    repeat (3) cyc();
    check_reset("rst");
    rst = 1'b0;
    cyc();

    // Ticks are ignored in IDLE
    run_ticks(2);
    check("idle_tick_state", int'(bus.state), 0);

    // Start with mode 11 -> latched as 00
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("start_state",  int'(bus.state),    1);
    check("start_mode_q", int'(bus.mode_q),   0);
    check("start_turn",   int'(bus.turn),     1);
    check("start_brst",   int'(bus.ball_rst), 1);
    bus.mode = 2'b01;

    // Serve countdown: exits on the 60th tick
    run_ticks(59);
    check("serve59_state", int'(bus.state), 1);
    run_ticks(1);
    check("serve60_state",  int'(bus.state),    2);
    check("launch_go",      int'(bus.ball_go),  1);
    check("launch_brst",    int'(bus.ball_rst), 0);
    check("launch_ai_en",   int'(bus.ai_en),    1);
    cyc();
    check("launch_go_1clk", int'(bus.ball_go),  0);
    check("midgame_mode_q", int'(bus.mode_q),   0);

    // start ignored during PLAY
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("play_start_ign", int'(bus.state), 2);

    // Hits toggle turn
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("hit1_turn", int'(bus.turn), 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hit2_turn", int'(bus.turn), 1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("hit3_turn", int'(bus.turn), 0);

    // Right miss scores for left
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("missr_score_l", int'(bus.score_l),   1);
    check("missr_sdir",    int'(bus.serve_dir), 1);
    check("missr_state",   int'(bus.state),     3);
    check("missr_ai_en",   int'(bus.ai_en),     0);
    check("missr_brst",    int'(bus.ball_rst),  1);

    run_ticks(89);
    check("scored89_state", int'(bus.state), 3);
    run_ticks(1);
    check("scored90_state", int'(bus.state), 1);
    check("reserve_turn",   int'(bus.turn),  1);
    run_ticks(60);
    check("play2_state", int'(bus.state), 2);

    // Double miss: replay, no score
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("dbl_state",   int'(bus.state),     3);
    check("dbl_score_l", int'(bus.score_l),   1);
    check("dbl_score_r", int'(bus.score_r),   0);
    check("dbl_sdir",    int'(bus.serve_dir), 1);

    run_ticks(150);
    check("play3_state", int'(bus.state), 2);
    check("play3_turn",  int'(bus.turn),  1);

    // Hit with miss: miss wins, turn untouched
    pulse(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("hitmiss_score_r", int'(bus.score_r),   1);
    check("hitmiss_turn",    int'(bus.turn),      1);
    check("hitmiss_sdir",    int'(bus.serve_dir), 0);
    check("hitmiss_state",   int'(bus.state),     3);

    run_ticks(90);
    check("serve4_turn", int'(bus.turn), 0);

    // Pause in SERVE delays exit by the paused ticks
    run_ticks(40);
    bus.pause = 1'b1;
    run_ticks(20);
    check("spause_state", int'(bus.state), 1);
    bus.pause = 1'b0;
    run_ticks(19);
    check("spause79_state", int'(bus.state), 1);
    run_ticks(1);
    check("spause80_state", int'(bus.state), 2);

    // Pause in PLAY: frozen, events ignored
    bus.pause = 1'b1;
    cyc();
    check("ppause_frz",   int'(bus.frz),   1);
    check("ppause_ai_en", int'(bus.ai_en), 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ppause_miss_state", int'(bus.state),   2);
    check("ppause_miss_score", int'(bus.score_r), 1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ppause_hit_turn", int'(bus.turn), 0);
    bus.pause = 1'b0;
    cyc();
    check("unpause_frz",   int'(bus.frz),   0);
    check("unpause_ai_en", int'(bus.ai_en), 1);

    // Left player runs to 7
    for (int i = 0; i < 6; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("win_score_l", int'(bus.score_l), i + 2);
      if (i < 5) begin
        check("win_mid_state", int'(bus.state), 3);
        run_ticks(150);
      end
    end
    check("over_state",  int'(bus.state),    4);
    check("over_winner", int'(bus.winner),   1);
    check("over_ai_en",  int'(bus.ai_en),    0);
    check("over_brst",   int'(bus.ball_rst), 1);

    // OVER holds through ticks and misses
    run_ticks(5);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("over_hold_state",   int'(bus.state),   4);
    check("over_hold_score_l", int'(bus.score_l), 7);
    check("over_hold_score_r", int'(bus.score_r), 1);

    // Restart clears and relatches mode
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_state",   int'(bus.state),   1);
    check("restart_score_l", int'(bus.score_l), 0);
    check("restart_score_r", int'(bus.score_r), 0);
    check("restart_winner",  int'(bus.winner),  0);
    check("restart_mode_q",  int'(bus.mode_q),  1);

    run_ticks(60);
    check("play5_state", int'(bus.state), 2);

    // Asynchronous reset mid-cycle in PLAY
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset("arst");
    cyc();
    rst = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
